// File: rtl/exception_ctrl.sv
// Exception/interrupt controller: latches faulting PC and cause, pulses a one-cycle
// fetch redirect, and serves MRS reads of ELR/ESR/exception counter.
module exception_ctrl #(
  parameter int            N          = 64,
  parameter logic [N-1:0]  EXC_VECTOR = 'h0000_0000_0000_00D8,
  parameter int            CNT_W      = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         InstrValid,
  input  logic         NotAnInstr,
  input  logic         ERet,
  input  logic         ExtIRQ,
  input  logic [N-1:0] PC_in,
  input  logic [1:0]   MrsSel,
  output logic         Exc,
  output logic [N-1:0] ExcVector,
  output logic         ExtIAck,
  output logic         InHandler,
  output logic [N-1:0] ELR,
  output logic [3:0]   ESR,
  output logic [N-1:0] MrsData
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] TAKE    = 2'd1;
  localparam logic [1:0] HANDLER = 2'd2;

  logic [1:0]       r_state;
  logic             r_exc;
  logic             r_ack;
  logic [N-1:0]     r_elr;
  logic [3:0]       r_esr;
  logic [CNT_W-1:0] r_cnt;

  logic       w_sync_evt;
  logic       w_take;
  logic       w_irq_take;
  logic       w_dbl_fault;
  logic [3:0] w_esr_code;
  logic [1:0] w_state_nxt;

  // Decoder-reported faults outrank the interrupt; IRQ does not need InstrValid.
  always_comb begin
    w_sync_evt  = InstrValid & (NotAnInstr | ERet);
    w_take      = (r_state == RUN) & (w_sync_evt | ExtIRQ);
    w_irq_take  = (r_state == RUN) & ~w_sync_evt & ExtIRQ;
    w_dbl_fault = (r_state == HANDLER) & InstrValid & NotAnInstr & ~ERet;

    w_esr_code = 4'b0001;
    if (InstrValid && NotAnInstr)
      w_esr_code = 4'b0010;
    else if (InstrValid && ERet)
      w_esr_code = 4'b0100;

    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_take) w_state_nxt = TAKE;
      TAKE:    w_state_nxt = HANDLER;
      HANDLER: if (InstrValid && ERet) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_exc   <= 1'b0;
      r_ack   <= 1'b0;
      r_elr   <= '0;
      r_esr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_exc   <= (w_state_nxt == TAKE);
      r_ack   <= w_irq_take;
      if (w_take) begin
        r_elr <= PC_in;
        r_esr <= w_esr_code;
        // Counter value is already visible while the redirect pulse is out.
        if (r_cnt != {CNT_W{1'b1}})
          r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_dbl_fault) begin
        r_esr[3] <= 1'b1;
      end
    end
  end

  always_comb begin
    MrsData = '0;
    case (MrsSel)
      2'b00:   MrsData = r_elr;
      2'b01:   MrsData = N'(r_esr);
      2'b10:   MrsData = N'(r_cnt);
      default: MrsData = '0;
    endcase
  end

  assign Exc       = r_exc;
  assign ExcVector = r_exc ? EXC_VECTOR : '0;
  assign ExtIAck   = r_ack;
  assign InHandler = (r_state != RUN);
  assign ELR       = r_elr;
  assign ESR       = r_esr;

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: directed scenarios plus random traffic, all outputs
// compared each cycle against a behavioural model of the controller.
module tb_exception_ctrl;

  localparam int          N       = 64;
  localparam int          CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [63:0] VEC     = 64'hD8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         InstrValid, NotAnInstr, ERet, ExtIRQ;
  logic [N-1:0] PC_in;
  logic [1:0]   MrsSel;
  logic         Exc, ExtIAck, InHandler;
  logic [N-1:0] ExcVector, ELR, MrsData;
  logic [3:0]   ESR;

  exception_ctrl #(.N(N), .EXC_VECTOR(VEC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst_n), .InstrValid(InstrValid), .NotAnInstr(NotAnInstr),
    .ERet(ERet), .ExtIRQ(ExtIRQ), .PC_in(PC_in), .MrsSel(MrsSel), .Exc(Exc),
    .ExcVector(ExcVector), .ExtIAck(ExtIAck), .InHandler(InHandler), .ELR(ELR),
    .ESR(ESR), .MrsData(MrsData)
  );

  always #5 clk = ~clk;

  typedef enum int {M_RUN, M_TAKE, M_HANDLER} mode_t;
  mode_t       m_mode;
  logic [63:0] m_elr;
  logic [3:0]  m_esr;
  int          m_cnt;
  bit          m_ack;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_elr = '0; m_esr = '0; m_cnt = 0; m_ack = 0;
  endtask

  task automatic model_take(input logic [63:0] pc, input logic [3:0] code);
    m_mode = M_TAKE;
    m_elr  = pc;
    m_esr  = code;
    m_cnt  = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
  endtask

  task automatic model_next(input bit iv, nai, er, irq, input logic [63:0] pc);
    m_ack = 0;
    case (m_mode)
      M_RUN: begin
        if (iv && nai) model_take(pc, 4'b0010);
        else if (iv && er) model_take(pc, 4'b0100);
        else if (irq) begin model_take(pc, 4'b0001); m_ack = 1; end
      end
      M_TAKE: m_mode = M_HANDLER;
      default: begin
        if (iv && er) m_mode = M_RUN;
        else if (iv && nai) m_esr[3] = 1'b1;
      end
    endcase
  endtask

  task automatic check_outputs();
    logic [63:0] exp_mrs;
    case (MrsSel)
      2'b00:   exp_mrs = m_elr;
      2'b01:   exp_mrs = {60'b0, m_esr};
      2'b10:   exp_mrs = 64'(m_cnt);
      default: exp_mrs = '0;
    endcase
    check_eq("exc",       {63'b0, Exc},       {63'b0, m_mode == M_TAKE});
    check_eq("excvector", ExcVector,          (m_mode == M_TAKE) ? VEC : 64'h0);
    check_eq("extiack",   {63'b0, ExtIAck},   {63'b0, m_ack});
    check_eq("inhandler", {63'b0, InHandler}, {63'b0, m_mode != M_RUN});
    check_eq("elr",       ELR,                m_elr);
    check_eq("esr",       {60'b0, ESR},       {60'b0, m_esr});
    check_eq("mrsdata",   MrsData,            exp_mrs);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit iv, nai, er, irq, input logic [63:0] pc, input logic [1:0] sel);
    InstrValid = iv; NotAnInstr = nai; ERet = er; ExtIRQ = irq; PC_in = pc; MrsSel = sel;
    #1;
    check_outputs();
    model_next(iv, nai, er, irq, pc);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(); step(0, 0, 0, 0, 64'h0, 2'b00); endtask
  task automatic do_eret(); step(1, 0, 1, 0, 64'h0, 2'b00); endtask

  initial begin
    rst_n = 1'b0; model_reset();
    InstrValid = 0; NotAnInstr = 0; ERet = 0; ExtIRQ = 1; PC_in = 64'h10; MrsSel = 2'b10;
    repeat (3) @(negedge clk);
    check_outputs();
    check_eq("rst_mrs_cnt", MrsData, 64'h0);
    rst_n = 1'b1;

    // Interrupt held through reset is taken on the first sampled edge.
    step(0, 0, 0, 1, 64'h10, 2'b00);
    check_eq("rst_rel_exc", {63'b0, Exc}, 64'h1);
    idle(); do_eret();

    step(1, 1, 0, 0, 64'h40, 2'b10);
    check_eq("inv_exc",  {63'b0, Exc}, 64'h1);
    check_eq("inv_vec",  ExcVector, 64'hD8);
    check_eq("inv_elr",  ELR, 64'h40);
    check_eq("inv_esr",  {60'b0, ESR}, 64'h2);
    idle();
    check_eq("inv_exc_off", {63'b0, Exc}, 64'h0);
    check_eq("inv_inh",     {63'b0, InHandler}, 64'h1);
    do_eret();

    step(0, 0, 0, 1, 64'h100, 2'b00);
    check_eq("irq_ack", {63'b0, ExtIAck}, 64'h1);
    check_eq("irq_esr", {60'b0, ESR}, 64'h1);
    check_eq("irq_mrs", MrsData, 64'h100);
    step(0, 0, 0, 1, 64'h0, 2'b00);
    check_eq("irq_ack_off", {63'b0, ExtIAck}, 64'h0);
    step(0, 1, 0, 1, 64'h0, 2'b00);
    step(1, 1, 0, 1, 64'h0, 2'b01);
    check_eq("dbl_esr", {60'b0, ESR}, 64'h9);
    check_eq("dbl_exc", {63'b0, Exc}, 64'h0);
    check_eq("dbl_elr", ELR, 64'h100);
    step(1, 0, 1, 1, 64'h0, 2'b00);
    check_eq("ret_inh", {63'b0, InHandler}, 64'h0);
    check_eq("ret_exc", {63'b0, Exc}, 64'h0);
    step(0, 0, 0, 1, 64'h200, 2'b00);
    check_eq("ret_irq_exc", {63'b0, Exc}, 64'h1);
    idle(); do_eret();

    step(1, 1, 0, 1, 64'h300, 2'b00);
    check_eq("prio_esr", {60'b0, ESR}, 64'h2);
    check_eq("prio_ack", {63'b0, ExtIAck}, 64'h0);
    idle(); do_eret();
    step(1, 0, 1, 0, 64'h80, 2'b00);
    check_eq("ieret_esr", {60'b0, ESR}, 64'h4);
    check_eq("ieret_elr", ELR, 64'h80);
    check_eq("ieret_exc", {63'b0, Exc}, 64'h1);
    idle();

    // Asynchronous reset in the middle of a handler.
    MrsSel = 2'b10;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_inh", {63'b0, InHandler}, 64'h0);
    check_eq("arst_cnt", MrsData, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0, 0, 64'h1000 + 64'(k), 2'b10);
      idle(); do_eret();
    end
    MrsSel = 2'b10;
    #1;
    check_eq("sat_cnt", MrsData, 64'h3);

    for (int c = 0; c < 400; c++) begin
      step(1'($urandom % 2), 1'($urandom % 4 == 0), 1'($urandom % 3 == 0),
           1'($urandom % 4 == 0), {$urandom, $urandom}, 2'($urandom % 4));
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
